// File: rtl/byte_out_fifo.sv
// Output byte FIFO for the decoder's byte packer: first-word-fall-through head,
// valid/ready drain, and a sticky overflow flag with a saturating drop counter.
module byte_out_fifo #(
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [7:0]        byte_i,
   input  logic              byte_valid_i,
   output logic [7:0]        data_o,
   output logic              valid_o,
   input  logic              ready_i,
   output logic [ADDR_W:0]   count_o,
   output logic              full_o,
   output logic              empty_o,
   output logic              overflow_o,
   output logic [7:0]        drop_cnt_o,
   input  logic              clr_ovf_i
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};

   logic [7:0]        mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic [ADDR_W:0]   count;
   logic              push;
   logic              pop;
   logic              drop;

   always_comb begin
      full_o  = (count == FULL_CNT);
      empty_o = (count == '0);
      valid_o = !empty_o;
      count_o = count;
      pop     = valid_o & ready_i;
      // A full FIFO still accepts a byte when the head leaves in the same cycle.
      push    = byte_valid_i & (!full_o | pop);
      drop    = byte_valid_i & full_o & !pop;
      data_o  = empty_o ? '0 : mem[rd_ptr];
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= byte_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (push && !pop) begin
            count <= count + 1'b1;
         end else if (pop && !push) begin
            count <= count - 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow_o <= 1'b0;
         drop_cnt_o <= '0;
      end else if (clr_ovf_i) begin
         overflow_o <= 1'b0;
         drop_cnt_o <= '0;
      end else if (drop) begin
         overflow_o <= 1'b1;
         if (drop_cnt_o != '1) begin
            drop_cnt_o <= drop_cnt_o + 1'b1;
         end
      end
   end

endmodule

// File: doc/byte_out_fifo.md
Name: byte_out_fifo

Overview:
- Downstream stage of the decoder's serial-to-parallel byte packer.
- Captures each single-cycle byte strobe into a synchronous circular FIFO and presents bytes to the system sink over a valid/ready handshake.
- The packer has no backpressure input. Bytes arriving while the FIFO is full are dropped, flagged and counted, never silently lost.

Parameters:
- ADDR_W, 4, pointer width; FIFO depth DEPTH = 2**ADDR_W (default 16 entries).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- byte_i  input  8  byte from the packer, sampled when byte_valid_i=1.
- byte_valid_i  input  1  single-cycle write strobe (may be high on consecutive cycles).
- data_o  output  8  head-of-FIFO byte, first-word-fall-through.
- valid_o  output  1  data_o holds a valid byte.
- ready_i  input  1  sink accepts; a pop occurs when valid_o & ready_i.
- count_o  output  ADDR_W+1  current occupancy, 0..DEPTH.
- full_o  output  1  count_o == DEPTH.
- empty_o  output  1  count_o == 0.
- overflow_o  output  1  sticky: at least one byte was dropped.
- drop_cnt_o  output  8  saturating count of dropped bytes.
- clr_ovf_i  input  1  synchronous clear of overflow_o and drop_cnt_o.

Behaviour:
- Reset (async, rst_n=0):
  - wr_ptr=0, rd_ptr=0, count_o=0.
  - empty_o=1, full_o=0, valid_o=0.
  - overflow_o=0, drop_cnt_o=0.
  - data_o=8'h00, because the output mux is forced to 0 when empty.
  - Memory contents are not reset.
  - Reset mid-stream discards all stored bytes. The first post-reset write lands at address 0.
- Storage:
  - DEPTH x 8 register array.
  - Write at wr_ptr, read at rd_ptr.
  - Each pointer is ADDR_W bits and wraps naturally from DEPTH-1 to 0.
  - Occupancy is tracked by a separate counter, not pointer comparison.
- Push (push = byte_valid_i & (!full_o | pop)):
  - mem[wr_ptr] <= byte_i; wr_ptr increments.
- Pop (pop = valid_o & ready_i):
  - rd_ptr increments.
  - data_o is combinational from mem[rd_ptr], gated to 0 when empty.
- Count update:
  - push & !pop: +1.
  - pop & !push: -1.
  - both or neither: unchanged.
- Latency:
  - A byte written on edge N is visible on data_o with valid_o=1 after edge N (cycle N+1).
  - No same-cycle write-to-read bypass. When empty, valid_o=0 and ready_i is ignored, even if byte_valid_i=1.
- Full with simultaneous pop:
  - When full_o=1 and pop and byte_valid_i occur together, both are accepted.
  - count stays DEPTH and no drop is recorded.
- Overflow (byte_valid_i & full_o & !pop):
  - The byte is discarded and the FIFO is unchanged.
  - overflow_o <= 1.
  - drop_cnt_o <= drop_cnt_o + 1, saturating at 8'hFF.
- clr_ovf_i:
  - Takes priority over a same-cycle drop: overflow_o <= 0 and drop_cnt_o <= 0.
  - The dropped byte in that cycle is not counted.
- valid_o and data_o:
  - valid_o = !empty_o.
  - data_o is stable while valid_o=1 and ready_i=0 (no pop, so rd_ptr holds).
- Flags:
  - full_o, empty_o and count_o derive from the registered count.
  - They are consistent in the same cycle.

Test Plan:
- Reset then write 8'hA5 (one strobe), ready_i=0 -> next cycle valid_o=1, data_o=A5, count_o=1; hold 5 cycles, data_o stays A5; assert ready_i 1 cycle -> empty_o=1, data_o=00.
- Write 16 bytes 8'h00..8'h0F back-to-back, ready_i=0 -> full_o=1, count_o=16; 17th strobe 8'hEE -> overflow_o=1, drop_cnt_o=1; then drain -> reads 00..0F in order, EE never appears.
- Full FIFO, byte_valid_i=1 (8'h55) with ready_i=1 same cycle -> count_o stays 16, overflow_o stays 0, 8'h55 read last after draining.
- Continuous stream: 40 bytes (incrementing from 8'h10) with ready_i=1 throughout -> all 40 received in order with no drops (checks pointer wrap-around); count_o never exceeds 1.
- 300 strobes into a full FIFO with ready_i=0 -> drop_cnt_o saturates at 8'hFF; clr_ovf_i pulse concurrent with a drop -> overflow_o=0, drop_cnt_o=0 next cycle.
- Fill 7 bytes, assert rst_n=0 asynchronously mid-cycle -> outputs reach reset values immediately; after release write 8'h3C -> data_o=3C, count_o=1.
